uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver. It consumes the 16x-oversampling `tick` from the baud rate generator, deserialises 8N1-style frames from the `rx` pin and presents each received byte with a one-cycle done strobe. It sits between the board RX pin/generator and the downstream RX FIFO or interface logic, and is the receive end of the UART link.

Parameters:
- DBIT, 8, data bits per frame, sent LSB first.
- SB_TICK, 16, ticks spent in the stop bit: 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clk pulse at 16x baud, from baud_rate_generator.
- rx  input  1  asynchronous serial line; idles high.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk pulse when a frame completes.
- frame_error  output  1  stop bit sampled low on the last frame.

Behaviour:
- Synchroniser
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - The FSM uses only the synchronised value `rx_s`, which lags `rx` by 2 clk.
- Reset
  - state=IDLE, s=0, n=0, shift register b=0.
  - dout=0, rx_done_tick=0, frame_error=0.
  - Reset mid-frame aborts the frame: no done pulse, dout unchanged from its reset value.
- Counters
  - s: tick counter, 4 bits minimum, wide enough for SB_TICK-1.
  - n: bit counter, $clog2(DBIT) bits.
  - b: DBIT-bit shift register.
  - Counters advance only in clocks where tick=1; all other clocks hold.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s==0 (tick not required), go to START and clear s. Ticks are otherwise ignored.
  - START: on tick with s==7 (mid start bit):
    - if rx_s==0: go to DATA, s=0, n=0.
    - else: false start / glitch, return to IDLE with no strobe.
  - START: on other ticks, s++.
  - DATA: on tick with s==15: s=0, b={rx_s, b[DBIT-1:1]}.
    - if n==DBIT-1: go to STOP.
    - else: n++.
  - DATA: on other ticks, s++.
  - STOP: on tick with s==SB_TICK-1, all registered in the same clock:
    - dout<=b
    - frame_error<=~rx_s
    - rx_done_tick<=1
    - go to IDLE.
  - STOP: on other ticks, s++.
- Outputs
  - rx_done_tick is high for exactly 1 clk, in the cycle after the completing tick edge. It is 0 in every other cycle.
  - dout and frame_error hold their values until the next completed frame.
  - A frame with a bad stop bit still updates dout and still pulses rx_done_tick.
- Sampling
  - Each data bit is sampled 16 ticks after the previous sample, i.e. at bit centre.
  - Stop-bit sampling happens at the end of the SB_TICK window.
- Back-to-back frames
  - A start edge present on rx_s in the cycle the FSM re-enters IDLE is detected in the next clock; no idle gap is required.
  - tick arriving in the same clock as the IDLE→START transition is not counted.
- Constant line levels
  - rx held low permanently: one frame is received with frame_error=1, then the FSM re-enters START repeatedly, emitting frames of 0x00 with frame_error=1.
  - rx held high: the FSM stays in IDLE.

Test Plan:
(All scenarios use DIVISOR=651, so tick occurs every 651 clk and 1 bit = 16 ticks = 10416 clk.)
- Reset then idle: reset held 3 clk, rx=1 for 20 bit times → dout=0x00, rx_done_tick never asserts, frame_error=0.
- Valid frame 0x55 (start, 1,0,1,0,1,0,1,0 LSB first, stop=1) → exactly one rx_done_tick pulse, 1 clk wide; dout=0x55; frame_error=0.
- Framing error: byte 0xA3 sent with stop bit=0 → rx_done_tick pulses once; dout=0xA3; frame_error=1. A following good frame 0x0F → frame_error returns to 0 and dout=0x0F.
- Glitch rejection: rx low for 3 ticks, then high → no rx_done_tick, FSM back in IDLE. A subsequent frame 0xC6 is received correctly.
- Back-to-back frames: 0x00 then 0xFF with no idle between stop and start → two pulses about 10 bit times apart; dout=0x00 then 0xFF; frame_error=0 both times.
- Reset mid-frame: assert reset during data bit 4 of 0x5A, release, then send 0x3C → no pulse for the aborted frame; next pulse shows dout=0x3C.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1-style serial receiver.
// Emits each received word with a one-clock done strobe.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_error
);

  localparam int SW_LOG = $clog2(SB_TICK);
  localparam int SW = (SW_LOG > 4) ? SW_LOG : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic [1:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [1:0]      sync;
  logic            rx_s;

  assign rx_s = sync[1];

  // Two-flop synchroniser; idles high like the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  // Frame FSM: start detect, bit-centre sampling, stop check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == S_STOP) begin
              dout         <= b;
              frame_error  <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
